// File: rtl/cross_bar_pkg.sv
// Shared crossbar definitions: bus widths, the master requester state
// encoding and a small elaboration-time helper.
package cross_bar_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        ADDR = 3'd2,
        RESP = 3'd3,
        REL  = 3'd4
    } mreq_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/cross_bar_down_counter.sv
// Loadable saturating down-counter, shared by the response timeout and the
// post-transaction request gap.
// Ports:
//   clk, aresetn  clock / asynchronous active-low reset
//   load          load load_val this cycle (takes priority over en)
//   load_val      value to load
//   en            decrement by one, holding at zero
//   count         current value
//   zero          count == 0
module cross_bar_down_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         aresetn,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         zero
);

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/cross_bar_master_req.sv
// Master-side requester for one crossbar master port. Takes one local command,
// requests the round-robin arbiter until granted, runs the slave address/ack
// and response phases, then releases req for REL_GAP cycles so the arbiter's
// falling-edge detector sees the release.
// Ports:
//   clk, aresetn                      clock / asynchronous active-low reset
//   cmd_valid/ready/wr/addr/wdata     local command handshake
//   req, grant                        this master's bit of the arbiter pair
//   s_req/s_wr/s_addr/s_wdata, s_ack  slave address phase
//   s_resp, s_rdata                   slave response strobe and read data
//   rsp_valid/rsp_rdata/rsp_err       one-cycle completion to the local side
//
// state | meaning
// IDLE  | ready for a local command
// REQ   | req high, waiting for grant
// ADDR  | granted, s_req high, waiting for s_ack
// RESP  | acked, waiting for s_resp or the response timeout
// REL   | req held low for the release gap
module cross_bar_master_req
    import cross_bar_pkg::*;
#(
    parameter int REL_GAP = 4,
    parameter int RESP_TO = 64
) (
    input  logic              clk,
    input  logic              aresetn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_wr,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              req,
    input  logic              grant,
    output logic              s_req,
    output logic              s_wr,
    output logic [ADDR_W-1:0] s_addr,
    output logic [DATA_W-1:0] s_wdata,
    input  logic              s_ack,
    input  logic              s_resp,
    input  logic [DATA_W-1:0] s_rdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam int TMR_W = $clog2(max_int(RESP_TO, REL_GAP) + 1);

    if (REL_GAP < 3) begin : g_rel_gap_check
        $error("cross_bar_master_req: REL_GAP must be at least 3");
    end

    mreq_state_t       state, state_nxt;
    logic              accept;
    logic              tmr_load, tmr_en, tmr_zero, tmr_done;
    logic [TMR_W-1:0]  tmr_val, tmr_count;

    logic              cmd_ready_nxt, req_nxt, s_req_nxt, s_wr_nxt;
    logic              rsp_valid_nxt, rsp_err_nxt;
    logic [ADDR_W-1:0] s_addr_nxt;
    logic [DATA_W-1:0] s_wdata_nxt, rsp_rdata_nxt;

    assign accept = cmd_valid && cmd_ready && (state == IDLE);

    // The FSM acts in the cycle the counter steps onto zero, so the timeout
    // fires RESP_TO cycles after the ack and req stays low exactly REL_GAP.
    assign tmr_done = tmr_zero || (tmr_count == TMR_W'(1));
    assign tmr_en   = (state == RESP) || (state == REL);

    cross_bar_down_counter #(.W(TMR_W)) u_timer (
        .clk      (clk),
        .aresetn  (aresetn),
        .load     (tmr_load),
        .load_val (tmr_val),
        .en       (tmr_en),
        .count    (tmr_count),
        .zero     (tmr_zero)
    );

    // State and output registers
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            req       <= 1'b0;
            s_req     <= 1'b0;
            s_wr      <= 1'b0;
            s_addr    <= '0;
            s_wdata   <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state     <= state_nxt;
            cmd_ready <= cmd_ready_nxt;
            req       <= req_nxt;
            s_req     <= s_req_nxt;
            s_wr      <= s_wr_nxt;
            s_addr    <= s_addr_nxt;
            s_wdata   <= s_wdata_nxt;
            rsp_valid <= rsp_valid_nxt;
            rsp_rdata <= rsp_rdata_nxt;
            rsp_err   <= rsp_err_nxt;
        end
    end

    // Next state and timer control
    always_comb begin
        state_nxt = state;
        tmr_load  = 1'b0;
        tmr_val   = '0;
        case (state)
            IDLE: if (accept) state_nxt = REQ;
            REQ:  if (grant) state_nxt = ADDR;
            ADDR: begin
                // s_ack wins over a simultaneous grant drop
                if (s_ack) begin
                    state_nxt = RESP;
                    tmr_load  = 1'b1;
                    tmr_val   = TMR_W'(RESP_TO);
                end else if (!grant) begin
                    state_nxt = REQ;
                end
            end
            RESP: begin
                if (s_resp || ((RESP_TO != 0) && tmr_done)) begin
                    state_nxt = REL;
                    tmr_load  = 1'b1;
                    tmr_val   = TMR_W'(REL_GAP - 1);
                end
            end
            REL:  if (tmr_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Next values of the registered outputs
    always_comb begin
        cmd_ready_nxt = (state_nxt == IDLE);
        req_nxt       = (state_nxt == REQ) || (state_nxt == ADDR) || (state_nxt == RESP);
        s_req_nxt     = (state_nxt == ADDR);
        s_wr_nxt      = s_wr;
        s_addr_nxt    = s_addr;
        s_wdata_nxt   = s_wdata;
        rsp_valid_nxt = 1'b0;
        rsp_rdata_nxt = rsp_rdata;
        rsp_err_nxt   = rsp_err;
        if (accept) begin
            s_wr_nxt    = cmd_wr;
            s_addr_nxt  = cmd_addr;
            s_wdata_nxt = cmd_wdata;
        end
        if ((state == RESP) && (state_nxt == REL)) begin
            rsp_valid_nxt = 1'b1;
            // s_resp wins over a same-cycle timeout
            if (s_resp) begin
                rsp_err_nxt   = 1'b0;
                rsp_rdata_nxt = s_wr ? '0 : s_rdata;
            end else begin
                rsp_err_nxt   = 1'b1;
                rsp_rdata_nxt = '0;
            end
        end
    end

endmodule

// File: tb/tb_cross_bar_master_req.sv
module tb_cross_bar_master_req;
    import cross_bar_pkg::*;

    localparam int REL_GAP = 4;
    localparam int RESP_TO = 8;

    logic              clk = 1'b0;
    logic              aresetn;
    logic              cmd_valid, cmd_ready, cmd_wr;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              req, grant, s_req, s_wr, s_ack, s_resp;
    logic [ADDR_W-1:0] s_addr;
    logic [DATA_W-1:0] s_wdata, s_rdata, rsp_rdata;
    logic              rsp_valid, rsp_err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    cross_bar_master_req #(.REL_GAP(REL_GAP), .RESP_TO(RESP_TO)) dut (
        .clk(clk), .aresetn(aresetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .req(req), .grant(grant),
        .s_req(s_req), .s_wr(s_wr), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_ack(s_ack), .s_resp(s_resp), .s_rdata(s_rdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    typedef struct packed {
        logic        cv, wr;
        logic [31:0] addr, wdata;
        logic        gnt, ack, resp;
        logic [31:0] rdata;
        logic        e_rdy, e_req, e_sreq, e_rv, e_err;
        logic [31:0] e_rdat;
        logic        e_swr;
        logic [31:0] e_saddr, e_swdata;
    } vec_t;

    vec_t vecs [20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %0s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cmd_valid = 0; cmd_wr = 0; cmd_addr = '0; cmd_wdata = '0;
        grant = 0; s_ack = 0; s_resp = 0; s_rdata = '0;
    endtask

    function automatic vec_t mk(input logic cv, wr, input logic [31:0] addr, wdata,
                                input logic gnt, ack, resp, input logic [31:0] rdata,
                                input logic rdy, rq, sreq, rv, err, input logic [31:0] rdat,
                                input logic swr, input logic [31:0] saddr, swdata);
        vec_t v;
        v = '{cv, wr, addr, wdata, gnt, ack, resp, rdata,
              rdy, rq, sreq, rv, err, rdat, swr, saddr, swdata};
        return v;
    endfunction

    // req must stay low at least REL_GAP cycles between transactions
    int low_run   = 0;
    bit seen_high = 0;
    always @(posedge clk) begin
        #1;
        if (!aresetn) begin
            seen_high = 0;
            low_run   = 0;
        end else if (req) begin
            if (seen_high && (low_run > 0))
                chk("req_low_gap_min", (low_run >= REL_GAP), 1'b1);
            seen_high = 1;
            low_run   = 0;
        end else begin
            low_run++;
        end
    end

    initial begin
        // read addr 0x10, grant 5 cycles after req, ack next, resp 3 later
        vecs[0]  = mk(1,0,32'h10,0, 0,0,0,0,                0,1,0,0,0,0, 0,32'h10,0);
        vecs[1]  = mk(0,0,0,0,      0,0,0,0,                0,1,0,0,0,0, 0,32'h10,0);
        vecs[2]  = mk(0,0,0,0,      0,0,0,0,                0,1,0,0,0,0, 0,32'h10,0);
        vecs[3]  = mk(0,0,0,0,      0,0,0,0,                0,1,0,0,0,0, 0,32'h10,0);
        vecs[4]  = mk(0,0,0,0,      0,0,0,0,                0,1,0,0,0,0, 0,32'h10,0);
        vecs[5]  = mk(0,0,0,0,      1,0,0,0,                0,1,1,0,0,0, 0,32'h10,0);
        vecs[6]  = mk(0,0,0,0,      1,1,0,0,                0,1,0,0,0,0, 0,32'h10,0);
        vecs[7]  = mk(0,0,0,0,      0,0,0,0,                0,1,0,0,0,0, 0,32'h10,0);
        vecs[8]  = mk(0,0,0,0,      0,0,0,0,                0,1,0,0,0,0, 0,32'h10,0);
        vecs[9]  = mk(0,0,0,0,      0,0,1,32'hA5A5_0001,    0,0,0,1,0,32'hA5A5_0001, 0,32'h10,0);
        vecs[10] = mk(0,0,0,0,      0,0,0,0,                0,0,0,0,0,0, 0,32'h10,0);
        vecs[11] = mk(0,0,0,0,      0,0,0,0,                0,0,0,0,0,0, 0,32'h10,0);
        vecs[12] = mk(0,0,0,0,      0,0,0,0,                1,0,0,0,0,0, 0,32'h10,0);
        // write addr 0x20; a second command while busy must be ignored
        vecs[13] = mk(1,1,32'h20,32'hDEAD_BEEF, 0,0,0,0,    0,1,0,0,0,0, 1,32'h20,32'hDEAD_BEEF);
        vecs[14] = mk(1,0,32'h99,32'h1234,      1,0,0,0,    0,1,1,0,0,0, 1,32'h20,32'hDEAD_BEEF);
        vecs[15] = mk(0,0,0,0,      1,1,0,0,                0,1,0,0,0,0, 1,32'h20,32'hDEAD_BEEF);
        vecs[16] = mk(0,0,0,0,      0,0,1,32'h5555_AAAA,    0,0,0,1,0,0, 1,32'h20,32'hDEAD_BEEF);
        vecs[17] = mk(0,0,0,0,      0,0,0,0,                0,0,0,0,0,0, 1,32'h20,32'hDEAD_BEEF);
        vecs[18] = mk(0,0,0,0,      0,0,0,0,                0,0,0,0,0,0, 1,32'h20,32'hDEAD_BEEF);
        vecs[19] = mk(0,0,0,0,      0,0,0,0,                1,0,0,0,0,0, 1,32'h20,32'hDEAD_BEEF);

        aresetn = 0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_req", req, 0);
        chk("rst_s_req", s_req, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_s_addr", s_addr, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        aresetn = 1;

        for (int i = 0; i < 20; i++) begin
            cmd_valid = vecs[i].cv;  cmd_wr = vecs[i].wr;
            cmd_addr = vecs[i].addr; cmd_wdata = vecs[i].wdata;
            grant = vecs[i].gnt; s_ack = vecs[i].ack;
            s_resp = vecs[i].resp; s_rdata = vecs[i].rdata;
            step();
            chk($sformatf("v%0d_cmd_ready", i), cmd_ready, vecs[i].e_rdy);
            chk($sformatf("v%0d_req", i), req, vecs[i].e_req);
            chk($sformatf("v%0d_s_req", i), s_req, vecs[i].e_sreq);
            chk($sformatf("v%0d_rsp_valid", i), rsp_valid, vecs[i].e_rv);
            chk($sformatf("v%0d_s_wr", i), s_wr, vecs[i].e_swr);
            chk($sformatf("v%0d_s_addr", i), s_addr, vecs[i].e_saddr);
            chk($sformatf("v%0d_s_wdata", i), s_wdata, vecs[i].e_swdata);
            if (vecs[i].e_rv) begin
                chk($sformatf("v%0d_rsp_err", i), rsp_err, vecs[i].e_err);
                chk($sformatf("v%0d_rsp_rdata", i), rsp_rdata, vecs[i].e_rdat);
            end
        end
        idle_inputs();

        // grant drop in ADDR, re-grant, then ack with a simultaneous grant drop
        cmd_valid = 1; cmd_addr = 32'h30;
        step(); cmd_valid = 0; cmd_addr = '0;
        grant = 1;
        step(); chk("roll_s_req_first", s_req, 1);
        grant = 0;
        step(); chk("roll_s_req_fall", s_req, 0); chk("roll_req_held", req, 1);
        step(); chk("roll_wait_s_req", s_req, 0);
        grant = 1;
        step(); chk("roll_s_req_again", s_req, 1); chk("roll_s_addr", s_addr, 32'h30);
        grant = 0; s_ack = 1;
        step(); chk("ackwin_s_req", s_req, 0); chk("ackwin_req", req, 1);
        s_ack = 0; grant = 1;
        step(); chk("resp_ignores_grant", s_req, 0);
        grant = 0; s_resp = 1; s_rdata = 32'h0000_0033;
        step(); chk("roll_rsp_valid", rsp_valid, 1); chk("roll_rsp_rdata", rsp_rdata, 32'h33);
        s_resp = 0; s_rdata = '0;
        repeat (3) step();
        chk("roll_back_idle", cmd_ready, 1);

        // response timeout, then late s_resp in REL and in IDLE
        cmd_valid = 1; cmd_addr = 32'h40;
        step(); cmd_valid = 0; cmd_addr = '0;
        grant = 1;
        step();
        s_ack = 1;
        step(); s_ack = 0; grant = 0;
        for (int k = 1; k < RESP_TO; k++) begin
            step();
            chk($sformatf("to_wait_%0d_rsp_valid", k), rsp_valid, 0);
        end
        step();
        chk("to_rsp_valid", rsp_valid, 1);
        chk("to_rsp_err", rsp_err, 1);
        chk("to_rsp_rdata", rsp_rdata, 0);
        chk("to_req_low", req, 0);
        step(); chk("to_pulse_one_cycle", rsp_valid, 0);
        s_resp = 1; s_rdata = 32'hFFFF_FFFF;
        step(); chk("late_resp_rel", rsp_valid, 0);
        s_resp = 0;
        step(); chk("to_back_idle", cmd_ready, 1);
        s_resp = 1;
        step(); chk("late_resp_idle", rsp_valid, 0);
        s_resp = 0; s_rdata = '0;

        // asynchronous reset while in RESP
        cmd_valid = 1; cmd_addr = 32'h50;
        step(); cmd_valid = 0; cmd_addr = '0;
        grant = 1;
        step();
        s_ack = 1;
        step(); s_ack = 0; grant = 0;
        chk("pre_rst_req", req, 1);
        #2 aresetn = 0;
        #1;
        chk("arst_req", req, 0);
        chk("arst_s_req", s_req, 0);
        chk("arst_cmd_ready", cmd_ready, 1);
        chk("arst_s_addr", s_addr, 0);
        s_resp = 1; s_rdata = 32'h1234_5678;
        step(); aresetn = 1;
        step(); chk("post_rst_rsp_valid", rsp_valid, 0); chk("post_rst_ready", cmd_ready, 1);
        s_resp = 0;
        step(); chk("post_rst_rsp_valid2", rsp_valid, 0); chk("post_rst_req", req, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
